sha3_burst_reader: RTL

Upstream feeder of the SHA3 burst-master input FIFO. Reads a contiguous message region from memory over an AXI4 read-only master port, in INCR bursts of 128-bit beats, and writes each beat into the 128-in/64-out bus FIFO in the same cycle. Paces itself on the FIFO's half-full flag so a whole burst always fits. Completion and error are reported to the SHA3 control logic.

---
 rtl/sha3_burst_reader_pkg.sv | 18 +
 rtl/sha3_burst_reader_if.sv | 28 ++
 rtl/sha3_burst_len_calc.sv | 29 ++
 rtl/sha3_burst_reader.sv | 136 +++++++++++++
 4 files changed

// File: rtl/sha3_burst_reader_pkg.sv
// Shared types and AXI constants for the SHA3 burst reader.
// Optional feature macro used by this slice: SHA3_BURST_4K_SPLIT_EN.
package sha3_burst_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      WAIT_ROOM = 3'd1,
      ADDR      = 3'd2,
      DATA      = 3'd3,
      DONE      = 3'd4
   } state_t;

   localparam logic [2:0] ARSIZE_16B   = 3'b100;
   localparam logic [1:0] ARBURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY    = 2'b00;
   localparam int         BEAT_BYTES   = 16;

endpackage

// File: rtl/sha3_burst_reader_if.sv
// AXI4 read-only channel between the burst reader (master) and memory (slave).
// Handshakes: a transfer happens on a rising edge where valid && ready; the
// sender holds payload stable while valid is high and ready is low.
interface sha3_burst_reader_if #(
   parameter int ADDR_W = 32
);
   logic              m_arvalid;
   logic              m_arready;
   logic [ADDR_W-1:0] m_araddr;
   logic [7:0]        m_arlen;
   logic [2:0]        m_arsize;
   logic [1:0]        m_arburst;
   logic              m_rvalid;
   logic              m_rready;
   logic [127:0]      m_rdata;
   logic [1:0]        m_rresp;
   logic              m_rlast;

   modport master (
      output m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
      input  m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
   );

   modport slave (
      input  m_arvalid, m_araddr, m_arlen, m_arsize, m_arburst, m_rready,
      output m_arready, m_rvalid, m_rdata, m_rresp, m_rlast
   );
endinterface

// File: rtl/sha3_burst_len_calc.sv
// Next burst length: min(BURST_BEATS, remaining) and, with
// SHA3_BURST_4K_SPLIT_EN defined, also the beats left before the next 4 KB page.
module sha3_burst_len_calc #(
   parameter int LEN_W       = 16,
   parameter int BURST_BEATS = 8,
   parameter int LW          = 4
) (
`ifdef SHA3_BURST_4K_SPLIT_EN
   input  logic [7:0]       page_off,
`endif
   input  logic [LEN_W-1:0] remaining,
   output logic [LW-1:0]    len
);
   logic [LEN_W:0] cap;
`ifdef SHA3_BURST_4K_SPLIT_EN
   logic [8:0]     room;
`endif

   always_comb begin
      cap = (LEN_W+1)'(BURST_BEATS);
      if ({1'b0, remaining} < cap) cap = {1'b0, remaining};
`ifdef SHA3_BURST_4K_SPLIT_EN
      // page_off is addr[11:4], so 256 - page_off beats remain in the page
      room = 9'd256 - {1'b0, page_off};
      if ((LEN_W+1)'(room) < cap) cap = (LEN_W+1)'(room);
`endif
      len = LW'(cap);
   end
endmodule

// File: rtl/sha3_burst_reader.sv
// Reads a contiguous region over AXI4 in INCR bursts and streams beats into
// the SHA3 input FIFO; 4 KB splitting is enabled by SHA3_BURST_4K_SPLIT_EN.
module sha3_burst_reader
   import sha3_burst_pkg::*;
#(
   parameter int ADDR_W      = 32,
   parameter int LEN_W       = 16,
   parameter int BURST_BEATS = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   src_addr,
   input  logic [LEN_W-1:0]    num_beats,
   output logic                busy,
   output logic                done,
   output logic                error,
   sha3_burst_reader_if.master axi,
   output logic                fifo_write_en,
   output logic [127:0]        fifo_write_data,
   input  logic                fifo_half_full,
   input  logic                fifo_full,
   output state_t              state
);
   localparam int LW = $clog2(BURST_BEATS) + 1;

   logic [ADDR_W-1:0] addr;
   logic [LEN_W-1:0]  remaining;
   logic [LW-1:0]     len_next;
   logic [LW-1:0]     len_q;
   logic [LW-1:0]     beat_cnt;
   logic              ar_valid;
   logic [ADDR_W-1:0] ar_addr;
   logic [7:0]        ar_len;
   logic              beat;
   logic              last_beat;

   sha3_burst_len_calc #(
      .LEN_W       (LEN_W),
      .BURST_BEATS (BURST_BEATS),
      .LW          (LW)
   ) u_len_calc (
`ifdef SHA3_BURST_4K_SPLIT_EN
      .page_off  (addr[11:4]),
`endif
      .remaining (remaining),
      .len       (len_next)
   );

   assign axi.m_arvalid = ar_valid;
   assign axi.m_araddr  = ar_addr;
   assign axi.m_arlen   = ar_len;
   assign axi.m_arsize  = ARSIZE_16B;
   assign axi.m_arburst = ARBURST_INCR;
   assign axi.m_rready  = (state == DATA) && !fifo_full;

   assign beat            = axi.m_rvalid && axi.m_rready;
   assign last_beat       = (beat_cnt == LW'(1));
   assign fifo_write_en   = beat;
   assign fifo_write_data = axi.m_rdata;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state     <= IDLE;
         addr      <= '0;
         remaining <= '0;
         len_q     <= '0;
         beat_cnt  <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         error     <= 1'b0;
         ar_valid  <= 1'b0;
         ar_addr   <= '0;
         ar_len    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  addr      <= src_addr & ~ADDR_W'(4'hF);
                  remaining <= num_beats;
                  error     <= 1'b0;
                  busy      <= 1'b1;
                  state     <= (num_beats == '0) ? DONE : WAIT_ROOM;
               end
            end
            WAIT_ROOM: begin
               // Half-full clear means a full-length burst still fits
               if (!fifo_half_full) begin
                  len_q    <= len_next;
                  ar_valid <= 1'b1;
                  ar_addr  <= addr;
                  ar_len   <= 8'(len_next - LW'(1));
                  state    <= ADDR;
               end
            end
            ADDR: begin
               if (axi.m_arready) begin
                  ar_valid <= 1'b0;
                  beat_cnt <= len_q;
                  state    <= DATA;
               end
            end
            DATA: begin
               if (beat) begin
                  beat_cnt <= beat_cnt - LW'(1);
                  if (axi.m_rresp != RESP_OKAY) error <= 1'b1;
                  // rlast is only checked; the beat counter ends the burst
                  if (axi.m_rlast != last_beat) error <= 1'b1;
                  if (last_beat) begin
                     addr      <= addr + ADDR_W'(len_q) * ADDR_W'(BEAT_BYTES);
                     remaining <= remaining - LEN_W'(len_q);
                     if (remaining == LEN_W'(len_q)) begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= DONE;
                     end else begin
                        state <= WAIT_ROOM;
                     end
                  end
               end
            end
            DONE: begin
               // Zero-beat jobs arrive here with done low and pulse one cycle later
               if (done) begin
                  done  <= 1'b0;
                  state <= IDLE;
               end else begin
                  done <= 1'b1;
                  busy <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
